branch_resolve_predict_unit: RTL and testbench
==============================================

Name: branch_resolve_predict_unit

Overview:
- Next-generation branch unit for Buraq-mini: it both predicts and resolves conditional branches.
- Fetch side: a direct-mapped Branch History Table (BHT) of 2-bit saturating counters gives a taken/not-taken prediction for the fetch PC.
- Execute side: evaluates the RV32 branch condition from func3, compares it with the prediction carried down the pipeline, and produces a registered mispredict/redirect one cycle later.
- Also updates the BHT and keeps performance counters. Sits between IF (prediction) and EX (resolution); its redirect drives the PC-select/flush logic.

Parameters:
- DataWidth, 32, width of operands and PCs.
- IndexBits, 6, log2 of BHT entries (default 64 entries).
- CntWidth, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  DataWidth  fetch PC to predict
- if_pred_taken  out  1  prediction for if_pc (combinational BHT read: counter MSB)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_func3  in  3  branch funct3
- ex_src1  in  DataWidth  rs1 value (forwarded)
- ex_src2  in  DataWidth  rs2 value (forwarded)
- ex_pc  in  DataWidth  PC of the EX branch
- ex_target  in  DataWidth  computed branch target (pc+imm)
- ex_pred_taken  in  1  prediction carried from IF for this instruction
- res_valid  out  1  registered: a branch resolved last cycle
- res_taken  out  1  registered actual outcome
- res_mispredict  out  1  registered: outcome != prediction
- res_redirect_pc  out  DataWidth  registered correct next PC
- res_illegal  out  1  registered: func3 is 010 or 011
- stat_branches  out  CntWidth  resolved branch count
- stat_mispredicts  out  CntWidth  mispredict count

Behaviour:
- Reset (async, rst_n=0):
  - all BHT entries = 2'b01 (weakly not-taken);
  - res_* = 0, res_redirect_pc = 0;
  - stat_* = 0.
  - Reset asserted mid-operation discards any pending resolution; no res_valid after release until a new branch resolves.
- Index: if_pc[IndexBits+1:2] for prediction, ex_pc[IndexBits+1:2] for update. PC bits [1:0] are ignored.
- Condition (combinational):
  - 000 BEQ: equal.
  - 001 BNE: not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010/011: taken=0, illegal=1.
- Resolve condition: resolve = ex_valid && ex_is_branch. On the next rising edge:
  - res_valid=1, res_taken=taken, res_illegal=illegal;
  - res_mispredict = taken ^ ex_pred_taken;
  - res_redirect_pc = taken ? ex_target : ex_pc+4 (modulo 2^DataWidth).
  - Latency: exactly 1 cycle.
  - If resolve=0, res_valid, res_mispredict and res_illegal are 0 next cycle; res_taken and res_redirect_pc hold their previous values.
- BHT update on resolve (same edge), entry at the ex_pc index:
  - taken: counter+1, saturating at 3.
  - not taken: counter−1, saturating at 0.
  - Illegal func3: no BHT update, and not counted in the stat counters.
- Read/update collision (if_pc index == ex_pc index in the same cycle): if_pred_taken reflects the pre-update value. No bypass.
- Counters:
  - stat_branches increments on each legal resolve.
  - stat_mispredicts increments on each legal mispredict.
  - Both wrap modulo 2^CntWidth.
- There is no stall input: the upstream pipeline guarantees ex_valid is a single-cycle pulse per instruction.

Decomposition:
- Shared package buraq_branch_pkg holds:
  - a func3 enum (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111);
  - the 2-bit counter typedef;
  - constants SNT=00, WNT=01, WT=10, ST=11.
- One natural sub-module: branch_compare (purely combinational func3 → taken/illegal evaluator). The top level holds the BHT, result registers and counters.

Test Plan:
- After reset, if_pc=0x100 → if_pred_taken=0. Then BEQ with src1=src2=5, ex_pc=0x100, target=0x140, pred=0 → next cycle res_valid=1, res_taken=1, res_mispredict=1, res_redirect_pc=0x140, stat_mispredicts=1.
- Repeat the taken BEQ at ex_pc=0x100 three more times → counter saturates at 3. One not-taken → counter=2, and if_pc=0x100 still predicts taken.
- BLT src1=0xFFFFFFFF, src2=1 → taken. BLTU on the same operands → not taken, redirect_pc=ex_pc+4.
- func3=011 with ex_valid=1 → res_illegal=1, res_taken=0, BHT entry and stat counters unchanged.
- Same-cycle collision, if_pc=ex_pc=0x200 with entry=01 and taken resolve → if_pred_taken=0 that cycle, then 1 on the following cycle.
- rst_n pulsed low for half a cycle right after a resolve → res_valid=0 immediately, all BHT entries back to 01, stat_* = 0.

Source files
------------

// File: rtl/buraq_branch_pkg.sv
// Shared types for the Buraq-mini branch predict/resolve unit: func3 codes,
// 2-bit BHT counter type and its saturating update.
package buraq_branch_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } func3_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t SNT = 2'b00;
    localparam bht_cnt_t WNT = 2'b01;
    localparam bht_cnt_t WT  = 2'b10;
    localparam bht_cnt_t ST  = 2'b11;

    // Saturating step toward the observed outcome.
    function automatic bht_cnt_t cnt_update(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t nxt;
        if (taken) begin
            nxt = (cnt == ST) ? ST : cnt + 2'(1);
        end else begin
            nxt = (cnt == SNT) ? SNT : cnt - 2'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational RV32 branch condition evaluator: func3 + operands -> taken/illegal.
module branch_compare
    import buraq_branch_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic [2:0]           func3,
    input  logic [DataWidth-1:0] src1,
    input  logic [DataWidth-1:0] src2,
    output logic                 taken_c,
    output logic                 illegal_c
);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (func3)
            F3_BEQ:  taken_c = (src1 == src2);
            F3_BNE:  taken_c = (src1 != src2);
            F3_BLT:  taken_c = ($signed(src1) <  $signed(src2));
            F3_BGE:  taken_c = ($signed(src1) >= $signed(src2));
            F3_BLTU: taken_c = (src1 <  src2);
            F3_BGEU: taken_c = (src1 >= src2);
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_predict_unit.sv
// Branch unit: BHT prediction at fetch, condition resolution at execute with a
// registered one-cycle redirect, BHT training and performance counters.
module branch_resolve_predict_unit
    import buraq_branch_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IndexBits = 6,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DataWidth-1:0] if_pc,
    output logic                 if_pred_taken,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic [2:0]           ex_func3,
    input  logic [DataWidth-1:0] ex_src1,
    input  logic [DataWidth-1:0] ex_src2,
    input  logic [DataWidth-1:0] ex_pc,
    input  logic [DataWidth-1:0] ex_target,
    input  logic                 ex_pred_taken,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 res_mispredict,
    output logic [DataWidth-1:0] res_redirect_pc,
    output logic                 res_illegal,
    output logic [CntWidth-1:0]  stat_branches,
    output logic [CntWidth-1:0]  stat_mispredicts
);

    localparam int unsigned Entries = 1 << IndexBits;

    bht_cnt_t             bht_q [Entries];
    bht_cnt_t             bht_d [Entries];
    logic [IndexBits-1:0] if_idx;
    logic [IndexBits-1:0] ex_idx;
    logic                 taken_c;
    logic                 illegal_c;
    logic                 resolve;
    logic                 unused_if_pc_bits;

    logic                 res_valid_q, res_valid_d;
    logic                 res_taken_q, res_taken_d;
    logic                 res_mispredict_q, res_mispredict_d;
    logic [DataWidth-1:0] res_redirect_pc_q, res_redirect_pc_d;
    logic                 res_illegal_q, res_illegal_d;
    logic [CntWidth-1:0]  stat_branches_q, stat_branches_d;
    logic [CntWidth-1:0]  stat_mispredicts_q, stat_mispredicts_d;

    assign if_idx  = if_pc[IndexBits+1:2];
    assign ex_idx  = ex_pc[IndexBits+1:2];
    assign resolve = ex_valid && ex_is_branch;
    assign unused_if_pc_bits = ^{if_pc[DataWidth-1:IndexBits+2], if_pc[1:0]};

    // Prediction reads the registered table, so a same-cycle update is not visible.
    assign if_pred_taken = bht_q[if_idx][1];

    branch_compare #(
        .DataWidth (DataWidth)
    ) u_compare (
        .func3     (ex_func3),
        .src1      (ex_src1),
        .src2      (ex_src2),
        .taken_c   (taken_c),
        .illegal_c (illegal_c)
    );

    always_comb begin
        bht_d              = bht_q;
        res_valid_d        = 1'b0;
        res_taken_d        = res_taken_q;
        res_mispredict_d   = 1'b0;
        res_redirect_pc_d  = res_redirect_pc_q;
        res_illegal_d      = 1'b0;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (resolve) begin
            res_valid_d       = 1'b1;
            res_taken_d       = taken_c;
            res_illegal_d     = illegal_c;
            res_mispredict_d  = taken_c ^ ex_pred_taken;
            res_redirect_pc_d = taken_c ? ex_target : ex_pc + DataWidth'(4);
            // Illegal encodings neither train the predictor nor count as branches.
            if (!illegal_c) begin
                bht_d[ex_idx]   = cnt_update(bht_q[ex_idx], taken_c);
                stat_branches_d = stat_branches_q + CntWidth'(1);
                if (taken_c ^ ex_pred_taken) begin
                    stat_mispredicts_d = stat_mispredicts_q + CntWidth'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Entries); i++) begin
                bht_q[i] <= WNT;
            end
            res_valid_q        <= 1'b0;
            res_taken_q        <= 1'b0;
            res_mispredict_q   <= 1'b0;
            res_redirect_pc_q  <= '0;
            res_illegal_q      <= 1'b0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            bht_q              <= bht_d;
            res_valid_q        <= res_valid_d;
            res_taken_q        <= res_taken_d;
            res_mispredict_q   <= res_mispredict_d;
            res_redirect_pc_q  <= res_redirect_pc_d;
            res_illegal_q      <= res_illegal_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign res_valid        = res_valid_q;
    assign res_taken        = res_taken_q;
    assign res_mispredict   = res_mispredict_q;
    assign res_redirect_pc  = res_redirect_pc_q;
    assign res_illegal      = res_illegal_q;
    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_predict_unit.sv
// Self-checking bench for branch_resolve_predict_unit: directed plan steps
// followed by random traffic against a behavioural predictor/resolver model.
module tb_branch_resolve_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [2:0]  ex_func3 = '0;
    logic [31:0] ex_src1 = '0, ex_src2 = '0, ex_pc = '0, ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic        res_valid, res_taken, res_mispredict, res_illegal;
    logic [31:0] res_redirect_pc, stat_branches, stat_mispredicts;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_bht [64];
    logic        m_valid, m_taken, m_mis, m_ill;
    logic [31:0] m_redir;
    logic [31:0] m_br, m_mp;

    always #5 clk = ~clk;

    branch_resolve_predict_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_func3         (ex_func3),
        .ex_src1          (ex_src1),
        .ex_src2          (ex_src2),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_mispredict   (res_mispredict),
        .res_redirect_pc  (res_redirect_pc),
        .res_illegal      (res_illegal),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0;
        m_redir = '0; m_br = '0; m_mp = '0;
    endtask

    function automatic int pc_slot(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("res_taken", 32'(res_taken), 32'(m_taken));
        chk("res_mispredict", 32'(res_mispredict), 32'(m_mis));
        chk("res_illegal", 32'(res_illegal), 32'(m_ill));
        chk("res_redirect_pc", res_redirect_pc, m_redir);
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mp);
    endtask

    // One cycle: drive at negedge, check prediction, clock, advance model, check results.
    task automatic step(input logic [31:0] ipc, input logic v, input logic br, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] epc,
                        input logic [31:0] tgt, input logic pred);
        logic tk, legal;
        if_pc = ipc; ex_valid = v; ex_is_branch = br; ex_func3 = f3;
        ex_src1 = a; ex_src2 = b; ex_pc = epc; ex_target = tgt; ex_pred_taken = pred;
        #1;
        chk("if_pred_taken", 32'(if_pred_taken), 32'(m_bht[pc_slot(ipc)] >= 2));
        @(posedge clk);
        tk    = cond_taken(f3, a, b);
        legal = !(f3 == 3'd2 || f3 == 3'd3);
        if (v && br) begin
            m_valid = 1; m_taken = tk; m_ill = !legal; m_mis = tk ^ pred;
            m_redir = tk ? tgt : epc + 32'd4;
            if (legal) begin
                if (tk) m_bht[pc_slot(epc)] = (m_bht[pc_slot(epc)] == 3) ? 3 : m_bht[pc_slot(epc)] + 1;
                else    m_bht[pc_slot(epc)] = (m_bht[pc_slot(epc)] == 0) ? 0 : m_bht[pc_slot(epc)] - 1;
                m_br++;
                if (tk ^ pred) m_mp++;
            end
        end else begin
            m_valid = 0; m_mis = 0; m_ill = 0;
        end
        @(negedge clk);
        check_outputs();
        ex_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Plan: cold prediction, then first taken BEQ mispredicts
        step(32'h100, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        step(32'h100, 1, 1, 3'd0, 5, 5, 32'h100, 32'h140, 0);
        chk("beq_redirect", res_redirect_pc, 32'h140);
        chk("beq_mispredicts", stat_mispredicts, 32'd1);
        for (int i = 0; i < 3; i++) step(32'h100, 1, 1, 3'd0, 5, 5, 32'h100, 32'h140, 1);
        step(32'h100, 1, 1, 3'd0, 5, 6, 32'h100, 32'h140, 1);
        step(32'h100, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        #1 chk("sat_then_dec_pred", 32'(if_pred_taken), 32'd1);

        // Signed vs unsigned compare of the same operands
        step(32'h0, 1, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h380, 0);
        chk("blt_taken", 32'(res_taken), 32'd1);
        step(32'h0, 1, 1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h380, 0);
        chk("bltu_redirect", res_redirect_pc, 32'h304);

        // Illegal func3: flagged, no training, no counting
        step(32'h100, 1, 1, 3'd3, 7, 7, 32'h100, 32'h500, 1);
        chk("illegal_flag", 32'(res_illegal), 32'd1);

        // Collision: update not visible until the next cycle
        step(32'h200, 1, 1, 3'd1, 1, 2, 32'h200, 32'h240, 0);
        step(32'h200, 0, 0, 3'd0, 0, 0, 0, 0, 0);

        // Boundary: wrap of redirect pc+4
        step(32'h0, 1, 1, 3'd0, 1, 2, 32'hFFFF_FFFC, 32'h10, 0);
        chk("redirect_wrap", res_redirect_pc, 32'h0);

        // Reset pulse right after a resolve
        ex_valid = 1; ex_is_branch = 1; ex_func3 = 3'd0; ex_src1 = 3; ex_src2 = 3;
        ex_pc = 32'h200; ex_target = 32'h280; ex_pred_taken = 0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        ex_valid = 0; ex_is_branch = 0;
        model_reset();
        #1 check_outputs();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i * 4);
            #0.1 chk("post_reset_bht", 32'(if_pred_taken), 32'd0);
        end
        step(32'h200, 0, 1, 3'd0, 0, 0, 32'h200, 0, 0);

        // Random traffic over a small PC pool to provoke collisions
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ipc, epc, a, b;
            logic [2:0]  f3;
            ipc = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            epc = ($urandom_range(0, 3) == 0) ? ipc : 32'($urandom_range(0, 15) * 4 + 32'h1000);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            f3  = 3'($urandom_range(0, 7));
            step(ipc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), f3, a, b,
                 epc, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
